// File: rtl/sdram_port_fifo.sv
// Client command queue in front of one port of the multi-port sdram controller.
// Optional watchdog on outstanding commands: define SDRAM_PORT_FIFO_TIMEOUT_EN.
module sdram_port_fifo #(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 32,
  parameter int DQM_WIDTH      = 4,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DQM_WIDTH-1:0]  cmd_byte_en,
  output logic                  rsp_valid,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] port_addr,
  output logic [DATA_WIDTH-1:0] port_data,
  output logic [DQM_WIDTH-1:0]  port_byte_en,
  output logic                  port_wr,
  output logic                  port_rd,
  input  logic                  port_available,
  input  logic                  port_ready,
  input  logic [DATA_WIDTH-1:0] port_q,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DQM_WIDTH-1:0]  be;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop;
  state_t        state, state_nxt;
  logic          req_q, req_nxt;
  logic          inflight_we;
  logic          load, accept, rsp_fire;
  logic          timeout;

  assign push   = cmd_valid && cmd_ready;
  assign accept = (state == ISSUE) && req_q && port_available;
  assign pop    = accept;
  assign head   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (!push && pop) count_nxt = count - (AW+1)'(1);
  end

  // cmd_ready is registered from the next count, so a pop never frees a slot
  // for the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      cmd_ready <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{we: cmd_we, addr: cmd_addr, data: cmd_data, be: cmd_byte_en};
  end

  // Request is a register raised one cycle after the port bus is loaded, so the
  // address/data are already stable when the controller first sees it.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    load      = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = ISSUE;
          load      = 1'b1;
        end
      end
      ISSUE: begin
        if (accept) begin
          state_nxt = WAIT;
          req_nxt   = 1'b0;
        end else begin
          req_nxt   = 1'b1;
        end
      end
      WAIT: begin
        if (port_ready || timeout) begin
          state_nxt = IDLE;
          rsp_fire  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      inflight_we  <= 1'b0;
      port_addr    <= '0;
      port_data    <= '0;
      port_byte_en <= '0;
      rsp_valid    <= 1'b0;
      rsp_we       <= 1'b0;
      rsp_data     <= '0;
    end else begin
      state     <= state_nxt;
      req_q     <= req_nxt;
      rsp_valid <= rsp_fire;
      if (load) begin
        inflight_we  <= head.we;
        port_addr    <= head.addr;
        port_data    <= head.data;
        port_byte_en <= head.be;
      end
      if (rsp_fire) begin
        rsp_we   <= inflight_we;
        rsp_data <= (inflight_we || timeout) ? '0 : port_q;
      end
    end
  end

  assign port_wr = req_q &&  inflight_we;
  assign port_rd = req_q && !inflight_we;
  assign busy    = (count != '0) || (state != IDLE);

`ifdef SDRAM_PORT_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  // tmo_cnt holds (WAIT cycles elapsed - 1); a late port_ready is dropped
  // because the FSM has already left WAIT.
  assign timeout = (state == WAIT) && !port_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt   <= '0;
      rsp_error <= 1'b0;
    end else begin
      tmo_cnt   <= (state == WAIT && state_nxt == WAIT) ? tmo_cnt + TW'(1) : '0;
      rsp_error <= timeout;
    end
  end
`else
  assign timeout   = 1'b0;
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_port_fifo.sv
// Scoreboard bench for sdram_port_fifo: stimulus queues expected issues and
// responses, a negedge monitor pops and compares them.
module tb_sdram_port_fifo;
  localparam int AW  = 21;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 16;

  typedef struct { logic we; logic [DW-1:0] data; logic err; } exp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; logic [BW-1:0] be; } iss_t;

  logic          clk, reset_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [BW-1:0] cmd_byte_en;
  logic          rsp_valid, rsp_we, rsp_error;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] port_addr;
  logic [DW-1:0] port_data;
  logic [BW-1:0] port_byte_en;
  logic          port_wr, port_rd, port_available, port_ready, busy;
  logic [DW-1:0] port_q;

  logic resp_pulse, spur;
  assign port_ready = resp_pulse | spur;

  sdram_port_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DQM_WIDTH(BW), .DEPTH(4),
                    .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_byte_en(cmd_byte_en),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .port_addr(port_addr), .port_data(port_data), .port_byte_en(port_byte_en),
    .port_wr(port_wr), .port_rd(port_rd), .port_available(port_available),
    .port_ready(port_ready), .port_q(port_q), .busy(busy)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int acc_cnt = 0, rsp_cnt = 0, dropped = 0;
  int hi_cnt = 0, last_hi = 0, acc_cyc = 0, rdy_cyc = -10;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] mm [int];
  exp_t exp_q[$];
  iss_t iss_q[$];
  logic auto_ready = 1'b1;
  int   lat = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Monitor: controller-side acceptances and client-side responses.
  initial forever begin
    @(negedge clk);
    if (port_wr && port_rd) check("wr_rd_exclusive", 1, 0);
    if (port_ready) rdy_cyc = cyc;
    if (port_wr || port_rd) hi_cnt++;
    if ((port_wr || port_rd) && port_available) begin
      iss_t e;
      check("issue_in_order", acc_cnt, rsp_cnt + dropped);
      check("issue_expected", iss_q.size() != 0, 1);
      if (iss_q.size() != 0) begin
        e = iss_q.pop_front();
        check("issue_we",   port_wr, e.we);
        check("issue_addr", port_addr, e.addr);
        check("issue_data", port_data, e.data);
        check("issue_be",   port_byte_en, e.be);
      end
      if (port_wr) mm[int'(port_addr)] = port_data;
      acc_we = port_wr; acc_addr = port_addr; acc_cyc = cyc;
      last_hi = hi_cnt; hi_cnt = 0;
      acc_cnt++;
    end
    if (rsp_valid) begin
      exp_t e;
      rsp_cnt++;
      check("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_we",    rsp_we, e.we);
        check("rsp_data",  rsp_data, e.data);
        check("rsp_error", rsp_error, e.err);
        if (e.err) check("rsp_tmo_latency", cyc, acc_cyc + TMO + 1);
        else       check("rsp_latency", cyc, rdy_cyc + 1);
      end
    end
  end

  // Controller model: answers each accepted command after `lat` extra cycles.
  initial begin
    int served = 0, lat_cnt = 0;
    resp_pulse = 0; port_q = '0;
    forever begin
      @(posedge clk); #1;
      resp_pulse = 0;
      if (!auto_ready || !reset_n) begin
        served = acc_cnt; lat_cnt = 0;
      end else if (acc_cnt != served) begin
        if (lat_cnt >= lat) begin
          resp_pulse = 1;
          port_q = acc_we ? 32'hDEAD_BEEF : (mm.exists(int'(acc_addr)) ? mm[int'(acc_addr)] : '0);
          served++; lat_cnt = 0;
        end else lat_cnt++;
      end
    end
  end

  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be);
    int b = 0;
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_data = d; cmd_byte_en = be;
    iss_q.push_back('{we, a, d, be});
    while (!cmd_ready && b < 200) begin @(posedge clk); #1; b++; end
    check("enqueue_timeout", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic expect_rsp(input logic we, input logic [DW-1:0] d, input logic err);
    exp_q.push_back('{we, d, err});
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || busy) && b < 500) begin @(posedge clk); #1; b++; end
    check("drain", (exp_q.size() == 0) && !busy, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, r0, b;
    reset_n = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_data = '0; cmd_byte_en = '0;
    port_available = 1; spur = 0;
    repeat (3) @(posedge clk); #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_port_wr", port_wr, 0);
    check("reset_port_rd", port_rd, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_port_addr", port_addr, 0);
    reset_n = 1;
    repeat (2) @(posedge clk); #1;

    // single write, earliest issue timing
    lat = 2;
    expect_rsp(1, 32'h0, 0);
    push(1, 21'h002020, 32'h1234, 4'hF);
    check("t1_wr_n0", port_wr, 0);
    @(posedge clk); #1; check("t1_wr_n1", port_wr, 0);
    @(posedge clk); #1; check("t1_wr_n2", port_wr, 1);
    drain();
    check("t1_wr_pulse_cycles", last_hi, 1);

    // write then read-back
    lat = 3;
    expect_rsp(1, 32'h0, 0);
    expect_rsp(0, 32'h0000_5678, 0);
    push(1, 21'h002021, 32'h5678, 4'hF);
    push(0, 21'h002021, 32'h0, 4'hF);
    drain();

    // five commands into a four-deep queue with the port stalled
    lat = 1; port_available = 0; base = acc_cnt;
    expect_rsp(1, 32'h0, 0);
    expect_rsp(1, 32'h0, 0);
    expect_rsp(0, 32'h1111_1111, 0);
    expect_rsp(0, 32'h2222_2222, 0);
    expect_rsp(1, 32'h0, 0);
    push(1, 21'h000100, 32'h1111_1111, 4'hF);
    push(1, 21'h000101, 32'h2222_2222, 4'h3);
    push(0, 21'h000100, 32'h0, 4'hF);
    push(0, 21'h000101, 32'h0, 4'hF);
    check("t3_full_ready", cmd_ready, 0);
    fork
      push(1, 21'h000102, 32'h3333_3333, 4'hC);
      begin
        repeat (3) @(posedge clk); #1;
        check("t3_full_hold", cmd_ready, 0);
        check("t3_no_issue_while_stalled", acc_cnt, base);
        port_available = 1;
      end
    join
    check("t3_fifth_after_dequeue", acc_cnt >= base + 1, 1);
    drain();
    check("t3_all_issued", acc_cnt, base + 5);

    // request held through 10 stalled cycles
    lat = 0; port_available = 0; base = acc_cnt;
    expect_rsp(0, 32'h0000_1234, 0);
    push(0, 21'h002020, 32'h0, 4'hF);
    b = 0;
    while (!port_rd && b < 50) begin @(negedge clk); b++; end
    check("t4_rd_raised", port_rd, 1);
    repeat (9) @(negedge clk);
    check("t4_rd_still_high", port_rd, 1);
    @(posedge clk); #1; port_available = 1;
    drain();
    check("t4_rd_high_cycles", last_hi, 11);
    check("t4_single_request", acc_cnt, base + 1);

    // spurious port_ready in IDLE
    r0 = rsp_cnt;
    @(posedge clk); #1; spur = 1;
    @(posedge clk); #1; spur = 0;
    repeat (4) @(posedge clk); #1;
    check("t5_spur_no_rsp", rsp_cnt, r0);
    check("t5_spur_idle", busy, 0);

    // reset while a read is in WAIT
    auto_ready = 0; base = acc_cnt;
    push(0, 21'h000300, 32'h0, 4'hF);
    b = 0;
    while (acc_cnt == base && b < 50) begin @(posedge clk); #1; b++; end
    check("t5_read_issued", acc_cnt, base + 1);
    repeat (2) @(posedge clk); #1;
    check("t5_busy_in_wait", busy, 1);
    #2 reset_n = 0; #1;
    check("t5_rst_port_rd", port_rd, 0);
    check("t5_rst_cmd_ready", cmd_ready, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rsp_valid", rsp_valid, 0);
    dropped++;
    repeat (2) @(posedge clk); #1;
    reset_n = 1;
    repeat (5) @(posedge clk); #1;
    check("t5_reset_no_rsp", rsp_cnt, r0);

    // normal operation resumes after reset
    auto_ready = 1; lat = 1;
    expect_rsp(0, 32'h0000_5678, 0);
    push(0, 21'h002021, 32'h0, 4'hF);
    drain();

`ifdef SDRAM_PORT_FIFO_TIMEOUT_EN
    // both commands time out; the second is issued after the first error
    auto_ready = 0; base = acc_cnt;
    expect_rsp(1, 32'h0, 1);
    expect_rsp(1, 32'h0, 1);
    push(1, 21'h000200, 32'hAAAA_0000, 4'hF);
    push(1, 21'h000201, 32'hBBBB_0000, 4'hF);
    drain();
    check("t6_next_issued", acc_cnt, base + 2);
    auto_ready = 1;
`endif

    check("final_iss_q_empty", iss_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sdram_port_fifo.md
Name: sdram_port_fifo

Overview:
- Client-side request queue that sits directly upstream of one port of the multi-port `sdram` controller.
- Accepts read/write commands from a client over a valid/ready interface and buffers them in a FIFO.
- Issues commands one at a time using the controller's port protocol (port_wr/port_rd, port_available, port_ready).
- Returns read data to the client in issue order; write completions are returned as acknowledgements.

Parameters:
- ADDR_WIDTH, 21: word address width; matches the controller PORT_ADDR_WIDTH.
- DATA_WIDTH, 32: data width; matches the controller DATA_WIDTH and PORT_OUTPUT_WIDTH.
- DQM_WIDTH, 4: byte-enable width.
- DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 4096: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, same clock as the controller clk.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  client command valid.
- cmd_ready  out  1  FIFO can accept a command (not full).
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  word address.
- cmd_data  in  DATA_WIDTH  write data.
- cmd_byte_en  in  DQM_WIDTH  byte enables.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_we  out  1  type of the completed command.
- rsp_data  out  DATA_WIDTH  read data; 0 for write completions.
- rsp_error  out  1  completion was a timeout (optional feature only, otherwise tied 0).
- port_addr  out  ADDR_WIDTH  to controller.
- port_data  out  DATA_WIDTH  to controller.
- port_byte_en  out  DQM_WIDTH  to controller.
- port_wr  out  1  write request to controller.
- port_rd  out  1  read request to controller.
- port_available  in  1  controller can take a new request on this port.
- port_ready  in  1  controller completion pulse; port_q is valid in the same cycle.
- port_q  in  DATA_WIDTH  read data from controller.
- busy  out  1  FIFO non-empty or a command is in flight.

Behaviour:
- Reset: all outputs 0 except cmd_ready = 1. FIFO pointers and count cleared; FSM returns to IDLE.
- Enqueue: occurs when cmd_valid && cmd_ready at a clk rising edge. Entry stores {we, addr, data, byte_en}.
  - cmd_ready = !full, registered.
  - count is clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
- Same-cycle enqueue and dequeue is allowed:
  - When full, cmd_ready is still 0 for that cycle; no bypass.
  - count is unchanged.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE: when the FIFO is non-empty. The head entry is registered onto the port_addr/port_data/port_byte_en outputs.
  - ISSUE: port_wr or port_rd (per entry we) is held high while port_available = 0.
  - ISSUE -> WAIT: on the first cycle with port_available = 1. The request is held high for exactly that cycle, then dropped. The FIFO pops in the same cycle.
  - WAIT: port_wr = port_rd = 0. port_addr/port_data/port_byte_en are held stable until completion.
  - WAIT -> IDLE: on port_ready = 1.
    - rsp_valid pulses the next cycle with rsp_we = in-flight type.
    - rsp_data = port_q registered on a read, 0 on a write.
- Earliest timing: a command enqueued at edge N can raise port_wr/port_rd after edge N+2.
- Only one command is in flight; commands complete strictly in order.
- port_ready seen in IDLE or ISSUE is ignored (no rsp_valid).
- port_wr and port_rd are never high together.
- rsp_valid has no back-pressure; the client must accept every pulse.
- busy = (count != 0) || state != IDLE.
- Reset asserted mid-operation: the FIFO is flushed, requests drop immediately (asynchronously), and no response is produced.

Optional Feature:
- Macro: SDRAM_PORT_FIFO_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If port_ready does not arrive within TIMEOUT_CYCLES cycles, the FSM returns to IDLE and issues rsp_valid with rsp_error = 1 and rsp_data = 0.
  - A port_ready arriving after the timeout is ignored.
- Undefined: no counter; WAIT persists indefinitely; rsp_error is constant 0.

Test Plan:
- Reset, then single write {addr 0x002020, data 0x1234, be 0xF} -> port_wr pulses exactly one cycle with those values; after port_ready, rsp_valid = 1 one cycle later with rsp_we = 1 and rsp_data = 0.
- Write 0x002021 <- 0x5678, then read 0x002021 -> port_rd issued only after the write's rsp_valid; rsp_data = 0x00005678, rsp_we = 0.
- Back-to-back enqueue of 5 commands with DEPTH = 4 and port_available held low -> cmd_ready drops after the 4th; the 5th is accepted only after the first dequeue; all 5 complete in order.
- port_available held low 10 cycles while in ISSUE -> port_rd stays high all 10 cycles and drops the cycle after acceptance; exactly one request.
- Spurious port_ready in IDLE, then reset_n pulsed low while in WAIT -> no rsp_valid in either case; cmd_ready = 1 and busy = 0 immediately after reset.
- SDRAM_PORT_FIFO_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and port_ready withheld -> rsp_valid with rsp_error = 1 at cycle 17 of WAIT; the next queued command is then issued.
